prog_loader: RTL and testbench

- Boot-time program loader: the writer side of the CPU memory interface.
- Receives a byte stream (valid/ready) carrying a length header, big-endian 32-bit words and an XOR checksum.
- Writes each assembled word into the unified instruction/data memory through the same address, write-data and write-enable port the CPU uses.
- Holds the CPU in reset until a load completes with a good checksum.

---
 rtl/prog_loader.sv | 126 ++++++++++++
 tb/tb_prog_loader.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/prog_loader.sv
// Boot-time program loader: takes a length-prefixed, checksummed byte stream and
// writes big-endian 32-bit words into the CPU memory, holding the CPU in reset until done.
module prog_loader #(
    parameter int ADDR_W    = 8,
    parameter int BASE_ADDR = 0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              in_valid,
    input  logic [7:0]        in_data,
    output logic              in_ready,
    output logic [ADDR_W-1:0] memaddr,
    output logic [31:0]       memwd,
    output logic              wmem,
    output logic              cpu_reset,
    output logic              done,
    output logic              err
);

    typedef enum logic [2:0] {
        IDLE, HDR_HI, HDR_LO, DATA, WRITE, CSUM, DONE, ERR
    } state_t;

    // Largest legal word count: the whole memory.
    localparam logic [16:0] LEN_MAX = 17'(1) << ADDR_W;

    state_t      state, state_nx;
    logic [7:0]  len_hi;
    logic [15:0] len;
    logic [15:0] word_idx;
    logic [1:0]  byte_idx;
    logic [23:0] shift;
    logic [7:0]  csum;

    logic        take;
    logic [15:0] len_new;
    logic [15:0] word_idx_inc;
    logic        restart;

    assign take         = in_valid & in_ready;
    assign len_new      = {len_hi, in_data};
    assign word_idx_inc = word_idx + 16'd1;
    assign restart      = start && (state == IDLE || state == DONE || state == ERR);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= IDLE;
        else        state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE, DONE, ERR: if (start) state_nx = HDR_HI;
            HDR_HI: if (take) state_nx = HDR_LO;
            HDR_LO: begin
                if (take) begin
                    if ({1'b0, len_new} > LEN_MAX) state_nx = ERR;
                    else if (len_new == 16'd0)     state_nx = CSUM;
                    else                           state_nx = DATA;
                end
            end
            DATA:  if (take && byte_idx == 2'd3) state_nx = WRITE;
            WRITE: state_nx = (word_idx_inc == len) ? CSUM : DATA;
            CSUM:  if (take) state_nx = (in_data == csum) ? DONE : ERR;
            default: state_nx = IDLE;
        endcase
    end

    // Datapath: header capture, word assembly, running checksum and word index.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            len_hi   <= '0;
            len      <= '0;
            word_idx <= '0;
            byte_idx <= '0;
            shift    <= '0;
            csum     <= '0;
            memaddr  <= '0;
            memwd    <= '0;
        end else if (restart) begin
            len_hi   <= '0;
            len      <= '0;
            word_idx <= '0;
            byte_idx <= '0;
            csum     <= '0;
        end else begin
            case (state)
                HDR_HI: if (take) len_hi <= in_data;
                HDR_LO: if (take) len <= len_new;
                DATA: begin
                    if (take) begin
                        shift    <= {shift[15:0], in_data};
                        byte_idx <= byte_idx + 2'd1;
                        csum     <= csum ^ in_data;
                        if (byte_idx == 2'd3) begin
                            memwd   <= {shift, in_data};
                            memaddr <= ADDR_W'(BASE_ADDR) + ADDR_W'(word_idx);
                        end
                    end
                end
                WRITE: word_idx <= word_idx_inc;
                default: ;
            endcase
        end
    end

    // Status outputs are registered from the next state so they move on the state edge.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            in_ready  <= 1'b0;
            wmem      <= 1'b0;
            cpu_reset <= 1'b1;
            done      <= 1'b0;
            err       <= 1'b0;
        end else begin
            in_ready  <= (state_nx == HDR_HI) || (state_nx == HDR_LO) ||
                         (state_nx == DATA)   || (state_nx == CSUM);
            wmem      <= (state_nx == WRITE);
            cpu_reset <= (state_nx != DONE);
            done      <= (state_nx == DONE);
            err       <= (state_nx == ERR);
        end
    end

endmodule

// File: tb/tb_prog_loader.sv
// Randomized bench for prog_loader: two instances (base 0 and base 254) share one
// stimulus stream; a stream-level model predicts the memory writes and the final status.
module tb_prog_loader;

    logic       clk = 1'b0;
    logic       reset;
    logic       start;
    logic       in_valid;
    logic [7:0] in_data;

    logic       in_ready_a, wmem_a, cpu_reset_a, done_a, err_a;
    logic [7:0] memaddr_a;
    logic [31:0] memwd_a;
    logic       in_ready_b, wmem_b, cpu_reset_b, done_b, err_b;
    logic [7:0] memaddr_b;
    logic [31:0] memwd_b;

    prog_loader #(.ADDR_W(8), .BASE_ADDR(0)) dut_a (
        .clk(clk), .reset(reset), .start(start), .in_valid(in_valid), .in_data(in_data),
        .in_ready(in_ready_a), .memaddr(memaddr_a), .memwd(memwd_a), .wmem(wmem_a),
        .cpu_reset(cpu_reset_a), .done(done_a), .err(err_a)
    );

    prog_loader #(.ADDR_W(8), .BASE_ADDR(254)) dut_b (
        .clk(clk), .reset(reset), .start(start), .in_valid(in_valid), .in_data(in_data),
        .in_ready(in_ready_b), .memaddr(memaddr_b), .memwd(memwd_b), .wmem(wmem_b),
        .cpu_reset(cpu_reset_b), .done(done_b), .err(err_b)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Captured write transactions {addr, data} per instance.
    logic [39:0] got_a[$];
    logic [39:0] got_b[$];

    always @(negedge clk) begin
        if (wmem_a) got_a.push_back({memaddr_a, memwd_a});
        if (wmem_b) got_b.push_back({memaddr_b, memwd_b});
    end

    // Reference model state for the current load.
    logic [31:0] words[$];
    logic [7:0]  stim[$];
    bit          exp_done;
    bit          hdr_bad;

    // Build the byte stream for header n and the words in 'words'; predict the outcome.
    task automatic build(input int n, input bit bad_csum);
        logic [7:0]  x;
        logic [15:0] n16;
        logic [31:0] w;
        stim.delete();
        n16 = 16'(n);
        stim.push_back(n16[15:8]);
        stim.push_back(n16[7:0]);
        hdr_bad = (n > 256);
        if (hdr_bad) begin
            exp_done = 1'b0;
            return;
        end
        x = 8'h00;
        for (int i = 0; i < n; i++) begin
            w = words[i];
            for (int k = 3; k >= 0; k--) begin
                stim.push_back(w[k*8 +: 8]);
                x = x ^ w[k*8 +: 8];
            end
        end
        if (bad_csum) stim.push_back(x ^ 8'(1 + $urandom_range(254)));
        else          stim.push_back(x);
        exp_done = !bad_csum;
    endtask

    task automatic rand_words(input int n);
        words.delete();
        for (int i = 0; i < n; i++) words.push_back($urandom);
    endtask

    task automatic do_start();
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        chk("start_in_ready", in_ready_a, 1);
        chk("start_done", done_a, 0);
        chk("start_err", err_a, 0);
        chk("start_cpu_reset", cpu_reset_a, 1);
    endtask

    // Present one byte, optionally after random idle cycles and with a start pulse alongside.
    task automatic send_byte(input logic [7:0] b, input int gap, input bit inj);
        int t;
        bit ok;
        t = 0;
        while ($urandom_range(99) < gap) begin
            in_valid = 1'b0;
            in_data  = 8'($urandom);
            @(posedge clk); #1;
        end
        in_valid = 1'b1;
        in_data  = b;
        if (inj) start = 1'b1;
        forever begin
            ok = in_ready_a;
            @(posedge clk); #1;
            start = 1'b0;
            if (ok) break;
            t++;
            if (t > 100) begin
                chk("byte_accept_timeout", 1, 0);
                break;
            end
        end
        in_valid = 1'b0;
    endtask

    task automatic check_writes(input string tag, input bit which, input int base);
        int          nexp;
        logic [39:0] g;
        logic [7:0]  a;
        nexp = hdr_bad ? 0 : words.size();
        chk({tag, "_count"}, which ? got_b.size() : got_a.size(), nexp);
        for (int i = 0; i < nexp; i++) begin
            if (i < (which ? got_b.size() : got_a.size())) begin
                g = which ? got_b[i] : got_a[i];
                a = 8'((base + i) % 256);
                chk({tag, "_wr"}, g, {a, words[i]});
            end
        end
    endtask

    task automatic run_load(input string tag, input int gap, input int inj_idx);
        got_a.delete();
        got_b.delete();
        do_start();
        for (int i = 0; i < stim.size(); i++) send_byte(stim[i], gap, (i == inj_idx));
        chk({tag, "_done"}, done_a, exp_done);
        chk({tag, "_err"}, err_a, !exp_done);
        chk({tag, "_cpu_reset"}, cpu_reset_a, !exp_done);
        chk({tag, "_in_ready"}, in_ready_a, 0);
        chk({tag, "_done_b"}, done_b, exp_done);
        repeat (2) @(posedge clk);
        #1;
        check_writes({tag, "_a"}, 1'b0, 0);
        check_writes({tag, "_b"}, 1'b1, 254);
    endtask

    initial begin
        reset    = 1'b0;
        start    = 1'b0;
        in_valid = 1'b0;
        in_data  = 8'h00;

        // Reset held for three cycles.
        repeat (3) @(posedge clk);
        #1;
        chk("rst_in_ready", in_ready_a, 0);
        chk("rst_wmem", wmem_a, 0);
        chk("rst_memaddr", memaddr_a, 0);
        chk("rst_memwd", memwd_a, 0);
        chk("rst_cpu_reset", cpu_reset_a, 1);
        chk("rst_done", done_a, 0);
        chk("rst_err", err_a, 0);
        reset = 1'b1;
        in_valid = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        in_valid = 1'b0;
        chk("idle_in_ready", in_ready_a, 0);
        chk("idle_cpu_reset", cpu_reset_a, 1);
        chk("idle_done", done_a, 0);

        // Two fixed words, no gaps, good then bad checksum.
        words.delete();
        words.push_back(32'h20080005);
        words.push_back(32'hAC020004);
        build(2, 1'b0);
        run_load("fixed_good", 0, -1);
        build(2, 1'b1);
        run_load("fixed_bad", 0, -1);
        build(2, 1'b0);
        run_load("after_err", 0, -1);

        // Empty payload, then oversize header aborting right after the length.
        words.delete();
        build(0, 1'b0);
        run_load("empty", 0, -1);
        build(257, 1'b0);
        run_load("oversize", 0, -1);
        in_valid = 1'b1;
        in_data  = 8'h5A;
        repeat (3) begin
            @(posedge clk); #1;
            chk("oversize_no_accept", in_ready_a, 0);
            chk("oversize_err_hold", err_a, 1);
        end
        in_valid = 1'b0;

        // Three words, gap-free then with random stalls and a start pulse during DATA.
        rand_words(3);
        build(3, 1'b0);
        run_load("three_nogap", 0, -1);
        run_load("three_gaps", 50, 5);

        // Random loads, including the full-memory length.
        for (int r = 0; r < 6; r++) begin
            rand_words(1 + $urandom_range(9));
            build(words.size(), ($urandom_range(3) == 0));
            run_load("rand", $urandom_range(40), -1);
        end
        rand_words(256);
        build(256, 1'b0);
        run_load("full", 0, -1);

        // Reset dropped in the middle of the second word.
        rand_words(3);
        build(3, 1'b0);
        got_a.delete();
        got_b.delete();
        do_start();
        for (int i = 0; i < 8; i++) send_byte(stim[i], 0, 1'b0);
        #2;
        reset = 1'b0;
        #1;
        chk("midrst_in_ready", in_ready_a, 0);
        chk("midrst_cpu_reset", cpu_reset_a, 1);
        chk("midrst_wmem", wmem_a, 0);
        chk("midrst_done", done_a, 0);
        chk("midrst_memaddr", memaddr_a, 0);
        in_valid = 1'b1;
        repeat (10) @(posedge clk);
        #1;
        reset = 1'b1;
        repeat (5) @(posedge clk);
        #1;
        in_valid = 1'b0;
        chk("midrst_writes", got_a.size(), 1);
        if (got_a.size() > 0) chk("midrst_first_wr", got_a[0], {8'd0, words[0]});
        chk("midrst_idle_ready", in_ready_a, 0);
        chk("midrst_idle_cpu_reset", cpu_reset_a, 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
